// File: rtl/commit_tracer_if.sv
// commit_tracer_if: issue/kill/retire inputs and retired-record/status outputs of the commit tracer.
interface commit_tracer_if;
   logic        iss_v;
   logic [31:0] iss_pc;
   logic [31:0] iss_inst;
   logic        kill;
   logic        ret_v;
   logic        wb_v;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] pass_pc;
   logic [31:0] fail_pc;
   logic        rec_v;
   logic [31:0] rec_pc;
   logic [31:0] rec_inst;
   logic        rec_wb_v;
   logic [4:0]  rec_rd;
   logic [31:0] rec_data;
   logic [31:0] retire_cnt;
   logic [1:0]  status;
   logic        done;
   logic        ovf;
   logic        unf;
   modport slave (
      input  iss_v, iss_pc, iss_inst, kill, ret_v, wb_v, wb_rd, wb_data, pass_pc, fail_pc,
      output rec_v, rec_pc, rec_inst, rec_wb_v, rec_rd, rec_data, retire_cnt, status, done, ovf, unf
   );
   modport master (
      output iss_v, iss_pc, iss_inst, kill, ret_v, wb_v, wb_rd, wb_data, pass_pc, fail_pc,
      input  rec_v, rec_pc, rec_inst, rec_wb_v, rec_rd, rec_data, retire_cnt, status, done, ovf, unf
   );
endinterface

// File: rtl/commit_tracer.sv
// commit_tracer: in-order retirement tracer emitting one record per retired instruction plus a PASS/FAIL status FSM.
// Defining COMMIT_TIMEOUT_EN adds a watchdog that enters TIMEOUT after TIMEOUT cycles without a record.
module commit_tracer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 10000
) (
   input logic            clk,
   input logic            reset,
   commit_tracer_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_e;
   state_e          st_q, st_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [63:0]     mem_q [DEPTH];
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic            rec_v_q, rec_wb_v_q;
   logic [4:0]      rec_rd_q;
   logic [31:0]     rec_pc_q, rec_inst_q, rec_data_q, ret_cnt_q;
   logic            done, full, empty, pop, push, drop, tmo_hit;
   logic [31:0]     head_pc;
   assign done    = st_q != RUN;
   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign pop     = !done && bus.ret_v && !empty;
   assign push    = !done && bus.iss_v && !bus.kill && (!full || pop);
   // a kill never removes the entry that is retiring in the same cycle
   assign drop    = !done && bus.kill && !bus.iss_v && !empty && !(cnt_q == (AW+1)'(1) && pop);
   assign head_pc = mem_q[head_q][63:32];
`ifdef COMMIT_TIMEOUT_EN
   logic [31:0] idle_q;
   always_ff @(posedge clk)
      idle_q <= (!reset || pop) ? '0 : (st_q == RUN) ? idle_q + 32'd1 : idle_q;
   assign tmo_hit = st_q == RUN && !pop && idle_q == 32'(TIMEOUT - 1);
`else
   assign tmo_hit = 1'b0;
`endif
   always_comb begin
      head_d = head_q + AW'(pop);
      tail_d = tail_q + AW'(push) - AW'(drop);
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop) - (AW+1)'(drop);
      ovf_d  = ovf_q | (!done && bus.iss_v && !bus.kill && full && !pop);
      unf_d  = unf_q | (!done && bus.ret_v && empty);
      st_d   = (pop && head_pc == bus.pass_pc) ? PASS :
               (pop && head_pc == bus.fail_pc) ? FAIL :
               tmo_hit ? TMO : st_q;
   end
   always_ff @(posedge clk)
      if (push) mem_q[tail_q] <= {bus.iss_pc, bus.iss_inst};
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q       <= RUN;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rec_v_q    <= 1'b0;
         rec_pc_q   <= '0;
         rec_inst_q <= '0;
         rec_wb_v_q <= 1'b0;
         rec_rd_q   <= '0;
         rec_data_q <= '0;
         ret_cnt_q  <= '0;
      end else begin
         st_q       <= st_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rec_v_q    <= pop;
         rec_pc_q   <= pop ? head_pc : '0;
         rec_inst_q <= pop ? mem_q[head_q][31:0] : '0;
         rec_wb_v_q <= pop && bus.wb_v;
         rec_rd_q   <= (pop && bus.wb_v) ? bus.wb_rd : '0;
         rec_data_q <= (pop && bus.wb_v) ? bus.wb_data : '0;
         ret_cnt_q  <= ret_cnt_q + 32'(pop);
      end
   end
   assign bus.rec_v      = rec_v_q;
   assign bus.rec_pc     = rec_pc_q;
   assign bus.rec_inst   = rec_inst_q;
   assign bus.rec_wb_v   = rec_wb_v_q;
   assign bus.rec_rd     = rec_rd_q;
   assign bus.rec_data   = rec_data_q;
   assign bus.retire_cnt = ret_cnt_q;
   assign bus.status     = st_q;
   assign bus.done       = done;
   assign bus.ovf        = ovf_q;
   assign bus.unf        = unf_q;
endmodule

// File: tb/tb_commit_tracer.sv
// tb_commit_tracer: directed and random checks of commit_tracer against a queue-based reference model.
module tb_commit_tracer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   commit_tracer_if bus();
   commit_tracer #(.DEPTH(4), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   int checks = 0;
   int errors = 0;
   logic [63:0] q[$];
   logic [1:0]  m_st;
   logic [31:0] m_cnt, m_pc, m_inst, m_data;
   logic        m_ovf, m_unf, m_rv, m_rwb;
   logic [4:0]  m_rd;
   int          m_idle;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("rec_v", 32'(bus.rec_v), 32'(m_rv));
      chk("rec_pc", bus.rec_pc, m_pc);
      chk("rec_inst", bus.rec_inst, m_inst);
      chk("rec_wb_v", 32'(bus.rec_wb_v), 32'(m_rwb));
      chk("rec_rd", 32'(bus.rec_rd), 32'(m_rd));
      chk("rec_data", bus.rec_data, m_data);
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      chk("status", 32'(bus.status), 32'(m_st));
      chk("done", 32'(bus.done), 32'(m_st != 2'd0));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("unf", 32'(bus.unf), 32'(m_unf));
   endtask
   task automatic idle_inputs();
      bus.iss_v = 0; bus.iss_pc = 0; bus.iss_inst = 0; bus.kill = 0;
      bus.ret_v = 0; bus.wb_v = 0; bus.wb_rd = 0; bus.wb_data = 0;
   endtask
   task automatic do_reset(input logic [31:0] p, input logic [31:0] f);
      @(negedge clk);
      reset = 0;
      idle_inputs();
      bus.pass_pc = p;
      bus.fail_pc = f;
      @(posedge clk);
      #1;
      q.delete();
      m_st = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_idle = 0;
      m_rv = 0; m_rwb = 0; m_rd = 0; m_pc = 0; m_inst = 0; m_data = 0;
      check_all();
   endtask
   task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst, input logic k,
                       input logic rv, input logic wv, input logic [4:0] rd, input logic [31:0] d);
      int sz;
      bit popped;
      logic [63:0] h;
      @(negedge clk);
      reset = 1;
      bus.iss_v = iv; bus.iss_pc = pc; bus.iss_inst = inst; bus.kill = k;
      bus.ret_v = rv; bus.wb_v = wv; bus.wb_rd = rd; bus.wb_data = d;
      m_rv = 0; m_rwb = 0; m_rd = 0; m_pc = 0; m_inst = 0; m_data = 0;
      if (m_st == 2'd0) begin
         sz = q.size();
         popped = rv && sz > 0;
         h = popped ? q[0] : 64'd0;
         if (rv && sz == 0) m_unf = 1;
         if (k && !iv && sz > 0 && !(sz == 1 && popped)) void'(q.pop_back());
         if (popped) begin
            void'(q.pop_front());
            m_rv = 1; m_pc = h[63:32]; m_inst = h[31:0];
            m_rwb = wv; m_rd = wv ? rd : 5'd0; m_data = wv ? d : 32'd0;
            m_cnt++;
            m_st = (h[63:32] == bus.pass_pc) ? 2'd1 : (h[63:32] == bus.fail_pc) ? 2'd2 : 2'd0;
            m_idle = 0;
         end
`ifdef COMMIT_TIMEOUT_EN
         else begin
            m_idle++;
            if (m_idle == 16) m_st = 2'd3;
         end
`endif
         if (iv && !k) begin
            if (sz < 4 || popped) q.push_back({pc, inst});
            else m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask
   task automatic iss(input logic [31:0] pc);
      step(1, pc, ~pc, 0, 0, 0, 5'd0, 32'd0);
   endtask
   task automatic ret();
      step(0, 32'd0, 32'd0, 0, 1, 0, 5'd0, 32'd0);
   endtask
   task automatic nop();
      step(0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
   endtask
   initial begin
      idle_inputs();
      bus.pass_pc = 32'h8000_0044;
      bus.fail_pc = 32'h8000_0080;
      // three issues, three retires, writeback on the last
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h100); iss(32'h104); iss(32'h108);
      ret();
      chk("seq_pc0", bus.rec_pc, 32'h100);
      ret();
      chk("seq_pc1", bus.rec_pc, 32'h104);
      step(0, 32'd0, 32'd0, 0, 1, 1, 5'd5, 32'hA5);
      chk("seq_pc2", bus.rec_pc, 32'h108);
      chk("seq_rd", 32'(bus.rec_rd), 32'd5);
      chk("seq_data", bus.rec_data, 32'hA5);
      chk("seq_cnt", bus.retire_cnt, 32'd3);
      nop();
      chk("seq_rec_low", 32'(bus.rec_v), 32'd0);
      // overflow: fifth issue into a full queue is dropped
      do_reset(32'h8000_0044, 32'h8000_0080);
      for (int i = 0; i < 5; i++) iss(32'h300 + 32'(4 * i));
      chk("ovf_set", 32'(bus.ovf), 32'd1);
      for (int i = 0; i < 4; i++) begin
         ret();
         chk("ovf_pc", bus.rec_pc, 32'h300 + 32'(4 * i));
      end
      ret();
      chk("ovf_tail_unf", 32'(bus.unf), 32'd1);
      chk("ovf_tail_norec", 32'(bus.rec_v), 32'd0);
      // full queue: issue and retire together both proceed
      do_reset(32'h8000_0044, 32'h8000_0080);
      for (int i = 0; i < 4; i++) iss(32'h600 + 32'(4 * i));
      step(1, 32'h610, 32'h1, 0, 1, 0, 5'd0, 32'd0);
      chk("full_pp_ovf", 32'(bus.ovf), 32'd0);
      // kill removes youngest; retire on empty sets unf
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h200); iss(32'h204);
      step(0, 32'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
      ret();
      chk("kill_pc", bus.rec_pc, 32'h200);
      ret();
      chk("kill_unf", 32'(bus.unf), 32'd1);
      // kill with issue discards the incoming one; kill vs sole retiring entry
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h400);
      step(1, 32'h404, 32'h0, 1, 0, 0, 5'd0, 32'd0);
      step(0, 32'd0, 32'd0, 1, 1, 0, 5'd0, 32'd0);
      chk("kill_ret_wins", bus.rec_pc, 32'h400);
      ret();
      chk("kill_iss_discard", 32'(bus.unf), 32'd1);
      step(0, 32'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
      // pass termination, then everything frozen
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h8000_0044);
      ret();
      chk("pass_status", 32'(bus.status), 32'd1);
      chk("pass_done", 32'(bus.done), 32'd1);
      chk("pass_rec", 32'(bus.rec_v), 32'd1);
      iss(32'h500);
      ret();
      chk("pass_frozen_rec", 32'(bus.rec_v), 32'd0);
      chk("pass_frozen_cnt", bus.retire_cnt, 32'd1);
      // fail termination, and pass priority when both addresses coincide
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h700); iss(32'h8000_0080);
      ret(); ret();
      chk("fail_status", 32'(bus.status), 32'd2);
      do_reset(32'h8000_0090, 32'h8000_0090);
      iss(32'h8000_0090);
      ret();
      chk("same_status", 32'(bus.status), 32'd1);
      // random traffic against the model
      do_reset(32'h8000_0044, 32'h8000_0080);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 255)), $urandom,
              $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)),
              5'($urandom), $urandom);
      // watchdog after a single record
      do_reset(32'h8000_0044, 32'h8000_0080);
      iss(32'h900);
      ret();
      for (int i = 0; i < 15; i++) nop();
      chk("tmo_before", 32'(bus.status), 32'd0);
      nop();
`ifdef COMMIT_TIMEOUT_EN
      chk("tmo_hit", 32'(bus.status), 32'd3);
`else
      for (int i = 0; i < 20; i++) nop();
      chk("tmo_absent", 32'(bus.status), 32'd0);
`endif
      do_reset(32'h8000_0044, 32'h8000_0080);
      chk("rst_status", 32'(bus.status), 32'd0);
      chk("rst_cnt", bus.retire_cnt, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/commit_tracer.md
COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 10000, cycles without retirement before TIMEOUT.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports iss_v/iss_pc/iss_inst  input  1/32/32  instruction issued from fetch stage.
REQ-006 SHALL have port kill  input  1  discard youngest non-retired instruction (wrong path).
REQ-007 SHALL have ports ret_v/wb_v/wb_rd/wb_data  input  1/1/5/32  oldest instruction retires, with optional register writeback.
REQ-008 SHALL have ports pass_pc/fail_pc  input  32/32  termination addresses, static after reset.
REQ-009 SHALL have ports rec_v/rec_pc/rec_inst/rec_wb_v/rec_rd/rec_data  output  1/32/32/1/5/32  retired-instruction record.
REQ-010 SHALL have port retire_cnt  output  32  retired-instruction count.
REQ-011 SHALL have ports status  output  2  (0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT) and done  output  1  (status != RUN).
REQ-012 SHALL have ports ovf/unf  output  1/1  sticky queue overflow/underflow errors.

Function
REQ-013 SHALL hold issued instructions in an in-order FIFO of DEPTH entries with head/tail pointers and an occupancy count 0..DEPTH.
REQ-014 SHALL push on iss_v when not full, or when full with ret_v popping in the same cycle.
REQ-015 SHALL, on iss_v with full queue and no pop, drop the instruction and set ovf.
REQ-016 SHALL pop the head on ret_v when non-empty; ret_v on empty queue SHALL set unf and emit no record (no same-cycle issue bypass).
REQ-017 SHALL register each record: rec_v high exactly one cycle after the popping ret_v, rec_pc/rec_inst from head entry, rec_wb_v/rec_rd/rec_data from same-cycle wb inputs; rec_rd/rec_data zero when wb_v low.
REQ-018 SHALL, on kill with iss_v, discard the incoming instruction; on kill without iss_v, remove the tail entry; kill on empty queue SHALL be ignored.
REQ-019 SHALL ignore kill when the only entry is popped in the same cycle (retire wins).
REQ-020 SHALL increment retire_cnt per record, wrapping 0xFFFFFFFF to 0.
REQ-021 SHALL implement status FSM: RUN->PASS when retiring pc equals pass_pc; RUN->FAIL when equals fail_pc (PASS if pass_pc==fail_pc); all non-RUN states sticky until reset; transition visible with the record.
REQ-022 SHALL, once done, suppress pushes, pops, records and retire_cnt updates.

Reset
REQ-023 SHALL, with reset low at posedge, clear queue, pointers, counts, ovf, unf, rec_* outputs to 0 and status to RUN, aborting any in-flight entries.

Configuration
REQ-024 SHALL, with COMMIT_TIMEOUT_EN defined, count cycles since the last record (or reset) in RUN and enter TIMEOUT when the count reaches TIMEOUT; a record resets the count.
REQ-025 SHALL, without COMMIT_TIMEOUT_EN, omit the counter; status never reaches 3.

Verification
REQ-026 Issue pc 0x100,0x104,0x108, retire three with wb_v=1 rd=5 data 0xA5 on last -> three records in order, last rec_rd=5 rec_data=0xA5, retire_cnt=3.
REQ-027 DEPTH=4: five issues without retire -> fifth dropped, ovf=1; four retires yield pcs of first four only.
REQ-028 Issue 0x200,0x204, kill, retire twice -> one record (0x200), second retire sets unf.
REQ-029 pass_pc=0x80000044; retire that pc -> status=1, done=1 with record; later issue/retire -> no records, retire_cnt unchanged.
REQ-030 COMMIT_TIMEOUT_EN, TIMEOUT=16: one retire then idle -> status=3 sixteen cycles after the record; reset low one cycle -> all outputs zero, status=0.
